// File: rtl/keypad_scan_fifo_if.sv
// Bus and keypad wiring for keypad_scan_fifo.
// The master side is the CPU bus plus the physical keypad (it drives the rows);
// the slave side is the scanner peripheral.
interface keypad_scan_fifo_if #(
   parameter int unsigned Rows = 4,
   parameter int unsigned Cols = 4
);
   logic [Rows-1:0] row;
   logic [Cols-1:0] col;
   logic            kbcs;
   logic            kbrd;
   logic [1:0]      low_addr;
   logic [15:0]     kbrdata;
   logic            kb_irq;

   modport master (
      output row, kbcs, kbrd, low_addr,
      input  col, kbrdata, kb_irq
   );

   modport slave (
      input  row, kbcs, kbrd, low_addr,
      output col, kbrdata, kb_irq
   );
endinterface

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: tick-paced column scan, press/release debounce,
// key-code FIFO, 4-digit hex entry register and an MMIO read port.
// Rows are sampled only on scan ticks; they are assumed to be settled and
// synchronised by the board (slow mechanical contacts, long tick period).
module keypad_scan_fifo #(
   parameter int unsigned Rows      = 4,
   parameter int unsigned Cols      = 4,
   parameter int unsigned ScanDiv   = 50000,
   parameter int unsigned DebTicks  = 3,
   parameter int unsigned FifoDepth = 8
) (
   input logic               clk_i,
   input logic               rst_ni,
   keypad_scan_fifo_if.slave bus
);
   localparam int unsigned Cw    = $clog2(Rows * Cols);
   localparam int unsigned TickW = $clog2(ScanDiv);
   localparam int unsigned CiW   = $clog2(Cols);
   localparam int unsigned RiW   = $clog2(Rows);
   localparam int unsigned PtrW  = $clog2(FifoDepth);
   localparam int unsigned CntW  = $clog2(FifoDepth + 1);
   localparam int unsigned DcW   = 4;

   typedef enum logic [1:0] {StIdle, StScan, StDeb, StHeld} state_e;

   state_e           state_q;
   logic [Cols-1:0]  col_q;
   logic [CiW-1:0]   ci_q;
   logic [Rows-1:0]  row_lat_q;
   logic [DcW-1:0]   dc_q;
   logic [DcW-1:0]   rc_q;
   logic [TickW-1:0] tick_cnt_q;
   logic [Cw-1:0]    mem_q [FifoDepth];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [CntW-1:0]  count_q;
   logic             overflow_q;
   logic [15:0]      entry_q;
   logic [15:0]      kbrdata_q;
   logic [15:0]      rdata_d;

   logic           tick, all_up, row_match, deb_done, rel_done, push;
   logic [RiW-1:0] row_idx;
   logic [Cw-1:0]  code;
   logic [3:0]     code4;
   logic           rd_en, empty, full, pop, wr_en, clr;

   assign tick      = (tick_cnt_q == TickW'(ScanDiv - 1));
   assign all_up    = &bus.row;
   assign row_match = (bus.row == row_lat_q);
   // dc/rc count samples already seen; this tick's sample completes the run
   assign deb_done  = (32'(dc_q) + 32'd1) >= DebTicks;
   assign rel_done  = (32'(rc_q) + 32'd1) >= DebTicks;
   assign push      = tick && (state_q == StDeb) && row_match && deb_done;
   assign code      = Cw'(int'(ci_q) * Rows + int'(row_idx));
   assign code4     = 4'(code);

   assign rd_en = bus.kbcs & bus.kbrd;
   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(FifoDepth));
   assign pop   = rd_en && (bus.low_addr == 2'b00) && !empty;
   assign clr   = rd_en && (bus.low_addr == 2'b11);
   // A full FIFO still accepts a push when a pop frees a slot in the same cycle
   assign wr_en = push && (!full || pop);

   assign bus.col     = col_q;
   assign bus.kbrdata = kbrdata_q;
   assign bus.kb_irq  = !empty;

   // Lowest contacting row of the latched pattern wins
   always_comb begin
      row_idx = '0;
      for (int i = Rows - 1; i >= 0; i--) begin
         if (!row_lat_q[i]) row_idx = RiW'(i);
      end
   end

   // Free-running scan tick divider
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   tick_cnt_q <= '0;
      else if (tick) tick_cnt_q <= '0;
      else           tick_cnt_q <= tick_cnt_q + TickW'(1);
   end

   // Scan / debounce FSM, advancing only on ticks
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         col_q     <= '0;
         ci_q      <= '0;
         row_lat_q <= '1;
         dc_q      <= '0;
         rc_q      <= '0;
      end else if (tick) begin
         unique case (state_q)
            StIdle: begin
               if (!all_up) begin
                  state_q <= StScan;
                  ci_q    <= '0;
                  col_q   <= ~Cols'(1);
               end
            end
            StScan: begin
               if (!all_up) begin
                  state_q   <= StDeb;
                  row_lat_q <= bus.row;
                  dc_q      <= DcW'(1);
               end else if (ci_q == CiW'(Cols - 1)) begin
                  state_q <= StIdle;
                  col_q   <= '0;
               end else begin
                  ci_q  <= ci_q + CiW'(1);
                  col_q <= ~(Cols'(1) << (ci_q + CiW'(1)));
               end
            end
            StDeb: begin
               if (!row_match) begin
                  state_q <= StIdle;
                  col_q   <= '0;
               end else if (deb_done) begin
                  state_q <= StHeld;
                  rc_q    <= '0;
               end else begin
                  dc_q <= dc_q + DcW'(1);
               end
            end
            StHeld: begin
               if (!all_up) begin
                  rc_q <= '0;
               end else if (rel_done) begin
                  state_q <= StIdle;
                  col_q   <= '0;
               end else begin
                  rc_q <= rc_q + DcW'(1);
               end
            end
         endcase
      end
   end

   // FIFO storage, no reset needed behind the pointers
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wptr_q] <= code;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + PtrW'(1);
         if (pop)   rptr_q <= rptr_q + PtrW'(1);
         if (wr_en && !pop)      count_q <= count_q + CntW'(1);
         else if (!wr_en && pop) count_q <= count_q - CntW'(1);
      end
   end

   // Sticky overflow and hex entry register; a clear read wins over a push
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_q <= 1'b0;
         entry_q    <= '0;
      end else if (clr) begin
         overflow_q <= 1'b0;
         entry_q    <= '0;
      end else if (push) begin
         if (full && !pop) overflow_q <= 1'b1;
         entry_q <= {entry_q[11:0], code4};
      end
   end

   // Read mux for the selected register
   always_comb begin
      rdata_d = '0;
      unique case (bus.low_addr)
         2'b00: if (!empty) rdata_d = {1'b1, 15'(mem_q[rptr_q])};
         2'b01: rdata_d = {7'd0, overflow_q, 8'(count_q)};
         2'b10: rdata_d = entry_q;
         2'b11: rdata_d = '0;
      endcase
   end

   // Read data register, loaded only on a qualified read strobe
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)    kbrdata_q <= '0;
      else if (rd_en) kbrdata_q <= rdata_d;
   end
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Self-checking bench for keypad_scan_fifo: a virtual keypad drives the rows
// from the column drive, and a queue-based model predicts every register read.
module tb_keypad_scan_fifo;
   localparam int unsigned Rows      = 4;
   localparam int unsigned Cols      = 4;
   localparam int unsigned ScanDiv   = 4;
   localparam int unsigned DebTicks  = 3;
   localparam int unsigned FifoDepth = 8;

   logic clk;
   logic rst_n;

   keypad_scan_fifo_if #(.Rows(Rows), .Cols(Cols)) kif ();

   keypad_scan_fifo #(
      .Rows     (Rows),
      .Cols     (Cols),
      .ScanDiv  (ScanDiv),
      .DebTicks (DebTicks),
      .FifoDepth(FifoDepth)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Virtual keypad: one key, contact pulls its row low when its column is driven
   logic key_on;
   int   key_c, key_r;
   always_comb begin
      kif.row = '1;
      if (key_on && (kif.col[key_c] == 1'b0)) kif.row[key_r] = 1'b0;
   end

   // Posedges since reset release; tick lands on every ScanDiv-th edge
   int unsigned edges;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   int total = 0;
   int bad   = 0;

   // Reference model
   int unsigned m_q[$];
   bit          m_ovf;
   logic [15:0] m_entry;

   function automatic void m_clear();
      m_q.delete();
      m_ovf   = 1'b0;
      m_entry = '0;
   endfunction

   function automatic void m_push(int unsigned code);
      if (m_q.size() < FifoDepth) m_q.push_back(code);
      else                        m_ovf = 1'b1;
      m_entry = {m_entry[11:0], 4'(code)};
   endfunction

   function automatic logic [15:0] m_read(logic [1:0] a);
      logic [15:0] r;
      r = '0;
      case (a)
         2'd0: if (m_q.size() > 0) r = 16'h8000 | 16'(m_q.pop_front());
         2'd1: r = {7'd0, m_ovf, 8'(m_q.size())};
         2'd2: r = m_entry;
         default: begin
            m_ovf   = 1'b0;
            m_entry = '0;
         end
      endcase
      return r;
   endfunction

   task automatic wait_ticks(input int n);
      repeat (n * ScanDiv) @(negedge clk);
   endtask

   // Park on the negedge right before a tick edge
   task automatic to_tick_eve();
      @(negedge clk);
      while ((edges % ScanDiv) != ScanDiv - 1) @(negedge clk);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
      @(negedge clk);
      kif.kbcs     = 1'b1;
      kif.kbrd     = 1'b1;
      kif.low_addr = a;
      @(negedge clk);
      d        = kif.kbrdata;
      kif.kbcs = 1'b0;
      kif.kbrd = 1'b0;
   endtask

   task automatic press(input int c, input int r);
      key_c  = c;
      key_r  = r;
      key_on = 1'b1;
      wait_ticks(Cols + DebTicks + 2);
      key_on = 1'b0;
      wait_ticks(DebTicks + 3);
      m_push(c * Rows + r);
   endtask

   task automatic do_reset();
      key_on       = 1'b0;
      kif.kbcs     = 1'b0;
      kif.kbrd     = 1'b0;
      kif.low_addr = 2'b00;
      rst_n        = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_clear();
   endtask

   task automatic test_reset();
      logic [15:0] d;
      do_reset();
      @(negedge clk);
      total++;
      if (kif.col !== 4'b0000) begin
         bad++;
         $display("FAIL reset_col: got %b want 0000", kif.col);
      end
      total++;
      if (kif.kbrdata !== 16'h0000) begin
         bad++;
         $display("FAIL reset_kbrdata: got %h want 0000", kif.kbrdata);
      end
      total++;
      if (kif.kb_irq !== 1'b0) begin
         bad++;
         $display("FAIL reset_irq: got %b want 0", kif.kb_irq);
      end
      bus_read(2'b01, d);
      total++;
      if (d !== 16'h0000) begin
         bad++;
         $display("FAIL reset_status: got %h want 0000", d);
      end
   endtask

   task automatic test_single_press();
      logic [15:0] d, e, hold;
      press(2, 1);
      total++;
      if (kif.kb_irq !== 1'b1) begin
         bad++;
         $display("FAIL single_irq: got %b want 1", kif.kb_irq);
      end
      bus_read(2'b01, d);
      e = m_read(2'b01);
      total++;
      if (d !== e) begin
         bad++;
         $display("FAIL single_count: got %h want %h", d, e);
      end
      // Chip select without a read strobe must not pop or reload
      hold = kif.kbrdata;
      @(negedge clk);
      kif.kbcs     = 1'b1;
      kif.low_addr = 2'b00;
      repeat (3) @(negedge clk);
      kif.kbcs = 1'b0;
      total++;
      if (kif.kbrdata !== hold || kif.kb_irq !== 1'b1) begin
         bad++;
         $display("FAIL cs_only: got data %h irq %b want %h irq 1", kif.kbrdata, kif.kb_irq, hold);
      end
      bus_read(2'b00, d);
      e = m_read(2'b00);
      total++;
      if (d !== e || d !== 16'h8009) begin
         bad++;
         $display("FAIL single_pop: got %h want %h", d, e);
      end
      bus_read(2'b00, d);
      e = m_read(2'b00);
      total++;
      if (d !== e) begin
         bad++;
         $display("FAIL single_pop_empty: got %h want %h", d, e);
      end
      total++;
      if (kif.kb_irq !== 1'b0) begin
         bad++;
         $display("FAIL single_irq_clear: got %b want 0", kif.kb_irq);
      end
   endtask

   task automatic test_bounce();
      logic [15:0] d, e;
      key_c  = 0;
      key_r  = 2;
      key_on = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wait_ticks(1);
         key_on = ~key_on;
      end
      key_on = 1'b1;
      wait_ticks(Cols + DebTicks + 2);
      key_on = 1'b0;
      wait_ticks(DebTicks + 3);
      m_push(0 * Rows + 2);
      bus_read(2'b01, d);
      e = m_read(2'b01);
      total++;
      if (d !== e) begin
         bad++;
         $display("FAIL bounce_count: got %h want %h", d, e);
      end
      // Two-tick glitch
      key_c  = 1;
      key_r  = 0;
      key_on = 1'b1;
      wait_ticks(2);
      key_on = 1'b0;
      wait_ticks(Cols + DebTicks + 2);
      bus_read(2'b01, d);
      e = m_read(2'b01);
      total++;
      if (d !== e) begin
         bad++;
         $display("FAIL glitch_count: got %h want %h", d, e);
      end
      bus_read(2'b00, d);
      e = m_read(2'b00);
      total++;
      if (d !== e) begin
         bad++;
         $display("FAIL bounce_pop: got %h want %h", d, e);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] d, e;
      for (int i = 0; i < 9; i++) press(i / Rows, i % Rows);
      bus_read(2'b01, d);
      e = m_read(2'b01);
      total++;
      if (d !== e || d !== 16'h0108) begin
         bad++;
         $display("FAIL ovf_status: got %h want %h", d, e);
      end
      for (int i = 0; i < 8; i++) begin
         bus_read(2'b00, d);
         e = m_read(2'b00);
         total++;
         if (d !== e) begin
            bad++;
            $display("FAIL ovf_pop%0d: got %h want %h", i, d, e);
         end
      end
      bus_read(2'b11, d);
      e = m_read(2'b11);
      total++;
      if (d !== e) begin
         bad++;
         $display("FAIL ovf_clear_read: got %h want %h", d, e);
      end
      bus_read(2'b01, d);
      e = m_read(2'b01);
      total++;
      if (d !== e) begin
         bad++;
         $display("FAIL ovf_status_cleared: got %h want %h", d, e);
      end
   endtask

   task automatic test_entry();
      logic [15:0] d, e;
      bus_read(2'b11, d);
      e = m_read(2'b11);
      for (int k = 1; k <= 5; k++) press(k / Rows, k % Rows);
      bus_read(2'b10, d);
      e = m_read(2'b10);
      total++;
      if (d !== e || d !== 16'h2345) begin
         bad++;
         $display("FAIL entry: got %h want %h", d, e);
      end
      for (int i = 0; i < 5; i++) begin
         bus_read(2'b00, d);
         e = m_read(2'b00);
         total++;
         if (d !== e) begin
            bad++;
            $display("FAIL entry_pop%0d: got %h want %h", i, d, e);
         end
      end
   endtask

   task automatic test_concurrency();
      logic [15:0] d, e;
      bus_read(2'b11, d);
      e = m_read(2'b11);
      for (int i = 0; i < 8; i++) press($urandom_range(0, Cols - 1), $urandom_range(0, Rows - 1));
      // Key at column 0 from idle: seen on tick 1, detected on tick 2, pushed on tick 4
      to_tick_eve();
      key_c  = 0;
      key_r  = 0;
      key_on = 1'b1;
      to_tick_eve();
      to_tick_eve();
      to_tick_eve();
      kif.kbcs     = 1'b1;
      kif.kbrd     = 1'b1;
      kif.low_addr = 2'b00;
      @(negedge clk);
      d        = kif.kbrdata;
      kif.kbcs = 1'b0;
      kif.kbrd = 1'b0;
      e = m_read(2'b00);
      m_push(0);
      total++;
      if (d !== e) begin
         bad++;
         $display("FAIL conc_pop: got %h want %h", d, e);
      end
      key_on = 1'b0;
      wait_ticks(DebTicks + 3);
      bus_read(2'b01, d);
      e = m_read(2'b01);
      total++;
      if (d !== e || d !== 16'h0008) begin
         bad++;
         $display("FAIL conc_status: got %h want %h", d, e);
      end
      for (int i = 0; i < 8; i++) begin
         bus_read(2'b00, d);
         e = m_read(2'b00);
         total++;
         if (d !== e) begin
            bad++;
            $display("FAIL conc_pop%0d: got %h want %h", i, d, e);
         end
      end
   endtask

   task automatic test_reset_mid_deb();
      logic [15:0] d;
      to_tick_eve();
      key_c  = 1;
      key_r  = 3;
      key_on = 1'b1;
      to_tick_eve();
      to_tick_eve();
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (kif.col !== 4'b0000 || kif.kb_irq !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_deb: got col %b irq %b want 0000 0", kif.col, kif.kb_irq);
      end
      repeat (2) @(negedge clk);
      key_on = 1'b0;
      rst_n  = 1'b1;
      m_clear();
      wait_ticks(Cols + DebTicks + 3);
      bus_read(2'b01, d);
      total++;
      if (d !== 16'h0000 || kif.kb_irq !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_deb_nopush: got %h irq %b want 0000 0", d, kif.kb_irq);
      end
   endtask

   task automatic test_random();
      logic [15:0] d, e;
      int unsigned act;
      logic [1:0]  a;
      for (int i = 0; i < 24; i++) begin
         act = $urandom_range(0, 4);
         if (act <= 2) begin
            press($urandom_range(0, Cols - 1), $urandom_range(0, Rows - 1));
         end else begin
            a = 2'($urandom_range(0, 3));
            bus_read(a, d);
            e = m_read(a);
            total++;
            if (d !== e) begin
               bad++;
               $display("FAIL rand_read%0d addr %0d: got %h want %h", i, a, d, e);
            end
         end
         total++;
         if (kif.kb_irq !== (m_q.size() > 0)) begin
            bad++;
            $display("FAIL rand_irq%0d: got %b want %b", i, kif.kb_irq, m_q.size() > 0);
         end
      end
      for (int i = 0; i < FifoDepth + 1; i++) begin
         bus_read(2'b00, d);
         e = m_read(2'b00);
         total++;
         if (d !== e) begin
            bad++;
            $display("FAIL rand_drain%0d: got %h want %h", i, d, e);
         end
      end
   endtask

   initial begin
      key_on       = 1'b0;
      key_c        = 0;
      key_r        = 0;
      kif.kbcs     = 1'b0;
      kif.kbrd     = 1'b0;
      kif.low_addr = 2'b00;
      rst_n        = 1'b0;
      m_clear();
      test_reset();
      test_single_press();
      test_bounce();
      test_overflow();
      test_entry();
      test_concurrency();
      test_reset_mid_deb();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
